// File: rtl/taxi_prbs_err_mon.sv
// PRBS error monitor: popcounts the checker's error vector, tracks lock with hysteresis, keeps BER counters.
// Latency: 2 cycles from a sampled word to locked / counters / err_pulse (popcount stage, then update stage).
// Backpressure: none; accepts one word per cycle, idle cycles (err_in_valid=0) leave all state untouched.
module taxi_prbs_err_mon #(
  parameter int DATA_W        = 8,
  parameter int CNT_W         = 32,
  parameter int LOCK_CNT      = 64,
  parameter int WIN_LEN       = 128,
  parameter int UNLOCK_THRESH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] err_in,
  input  logic              err_in_valid,
  input  logic              clear,
  output logic              locked,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [CNT_W-1:0]  err_word_cnt,
  output logic [CNT_W-1:0]  err_bit_cnt,
  output logic              err_pulse
);

  localparam int POP_W  = $clog2(DATA_W + 1);
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W  = $clog2(WIN_LEN + 1);
  localparam int BAD_W  = $clog2(UNLOCK_THRESH + 1);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  state_t            state;
  logic [GOOD_W-1:0] good_cnt;
  logic [WIN_W-1:0]  win_cnt;
  logic [BAD_W-1:0]  bad_cnt;

  logic [POP_W-1:0]  pop_c;
  logic              s1_vld;
  logic [POP_W-1:0]  s1_pop;
  logic              s1_err;
  logic              count_word;

  // Saturating add: clamps at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // Number of mismatching bits in the incoming error vector.
  always_comb begin
    pop_c = '0;
    for (int i = 0; i < DATA_W; i++) begin
      pop_c = pop_c + POP_W'(err_in[i]);
    end
  end

  // Stage 1: register popcount and valid flag; reset flushes the word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_pop <= '0;
    end else begin
      s1_vld <= err_in_valid;
      if (err_in_valid) begin
        s1_pop <= pop_c;
      end
    end
  end

  assign s1_err     = (s1_pop != '0);
  // Counting decision uses the lock state before this word's update, so the
  // locking word is excluded and the unlocking word is included.
  assign count_word = s1_vld && locked;

  // Stage 2 lock FSM: clean-run hysteresis to lock, windowed errored-word count to unlock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_UNLOCKED;
      locked   <= 1'b0;
      good_cnt <= '0;
      win_cnt  <= '0;
      bad_cnt  <= '0;
    end else if (s1_vld) begin
      case (state)
        ST_UNLOCKED: begin
          if (s1_err) begin
            good_cnt <= '0;
          end else if (good_cnt == GOOD_W'(LOCK_CNT - 1)) begin
            state    <= ST_LOCKED;
            locked   <= 1'b1;
            good_cnt <= '0;
            win_cnt  <= '0;
            bad_cnt  <= '0;
          end else begin
            good_cnt <= good_cnt + GOOD_W'(1);
          end
        end
        ST_LOCKED: begin
          // Threshold is checked before window close so unlock wins on the last word.
          if (s1_err && (bad_cnt == BAD_W'(UNLOCK_THRESH - 1))) begin
            state    <= ST_UNLOCKED;
            locked   <= 1'b0;
            good_cnt <= '0;
            win_cnt  <= '0;
            bad_cnt  <= '0;
          end else if (win_cnt == WIN_W'(WIN_LEN - 1)) begin
            win_cnt <= '0;
            bad_cnt <= '0;
          end else begin
            win_cnt <= win_cnt + WIN_W'(1);
            bad_cnt <= bad_cnt + BAD_W'(s1_err);
          end
        end
        default: begin
          state  <= ST_UNLOCKED;
          locked <= 1'b0;
        end
      endcase
    end
  end

  // Stage 2 statistics: saturating counters; clear overrides any same-cycle update.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt     <= '0;
      err_word_cnt <= '0;
      err_bit_cnt  <= '0;
      err_pulse    <= 1'b0;
    end else begin
      err_pulse <= count_word && s1_err;
      if (clear) begin
        word_cnt     <= '0;
        err_word_cnt <= '0;
        err_bit_cnt  <= '0;
      end else if (count_word) begin
        word_cnt     <= sat_add(word_cnt, CNT_W'(1));
        err_word_cnt <= sat_add(err_word_cnt, CNT_W'(s1_err));
        err_bit_cnt  <= sat_add(err_bit_cnt, CNT_W'(s1_pop));
      end
    end
  end

endmodule
